// File: rtl/branch_predictor_param.sv
// Dynamic branch predictor: saturating-counter BHT plus tagged BTB, combinational fetch lookup.
// Optional gshare indexing with a global history register is enabled by defining GSHARE_EN.
module branch_predictor_param #(
  parameter int BHT_IDX_W = 10,
  parameter int CNT_W     = 2,
  parameter int BTB_IDX_W = 6,
  parameter int TAG_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pcF,
  output logic                 pred_takenF,
  output logic [31:0]          pred_targetF,
  output logic                 pred_hitF,
  output logic [BHT_IDX_W-1:0] pred_ghrF,
  input  logic                 upd_valid,
  input  logic                 upd_is_branch,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_pred_taken,
  input  logic [BHT_IDX_W-1:0] upd_ghr,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispred
);

  localparam int BHT_N = 2 ** BHT_IDX_W;
  localparam int BTB_N = 2 ** BTB_IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  bht        [BHT_N];
  logic              btb_valid  [BTB_N];
  logic [TAG_W-1:0]  btb_tag    [BTB_N];
  logic [31:0]       btb_target [BTB_N];

  logic [BHT_IDX_W-1:0] look_bht_idx;
  logic [BHT_IDX_W-1:0] upd_bht_idx;
  logic [BTB_IDX_W-1:0] look_btb_idx;
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic [TAG_W-1:0]     look_tag;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_br;
  logic [CNT_W-1:0]     upd_cnt;
  logic                 unused_bits;

  assign upd_br = upd_valid & upd_is_branch;

`ifdef GSHARE_EN
  logic [BHT_IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (upd_br) begin
      ghr <= {ghr[BHT_IDX_W-2:0], upd_taken};
    end
  end

  assign pred_ghrF    = ghr;
  assign look_bht_idx = pcF[BHT_IDX_W+1:2] ^ ghr;
  assign upd_bht_idx  = upd_pc[BHT_IDX_W+1:2] ^ upd_ghr;
`else
  assign pred_ghrF    = '0;
  assign look_bht_idx = pcF[BHT_IDX_W+1:2];
  assign upd_bht_idx  = upd_pc[BHT_IDX_W+1:2];
`endif

  // Address bits outside the index/tag fields (and upd_ghr without gshare) are don't-care.
  assign unused_bits = ^{pcF, upd_pc, upd_ghr};

  assign look_btb_idx = pcF[BTB_IDX_W+1:2];
  assign look_tag     = pcF[BTB_IDX_W+2 +: TAG_W];
  assign upd_btb_idx  = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag      = upd_pc[BTB_IDX_W+2 +: TAG_W];
  assign upd_cnt      = bht[upd_bht_idx];

  // Lookup reads committed state only; a same-cycle update lands on the next edge.
  always_comb begin
    pred_hitF    = btb_valid[look_btb_idx] && (btb_tag[look_btb_idx] == look_tag);
    pred_takenF  = pred_hitF && bht[look_bht_idx][CNT_W-1];
    pred_targetF = pred_hitF ? btb_target[look_btb_idx] : (pcF + 32'd4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= CNT_INIT;
    end else if (upd_br) begin
      if (upd_taken && (upd_cnt != CNT_MAX)) begin
        bht[upd_bht_idx] <= upd_cnt + CNT_ONE;
      end else if (!upd_taken && (upd_cnt != '0)) begin
        bht[upd_bht_idx] <= upd_cnt - CNT_ONE;
      end
    end
  end

  // Only taken branches allocate; not-taken ones leave the entry alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_br && upd_taken) begin
      btb_valid[upd_btb_idx]  <= 1'b1;
      btb_tag[upd_btb_idx]    <= upd_tag;
      btb_target[upd_btb_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (upd_br) begin
      if (perf_branches != 32'hFFFF_FFFF) perf_branches <= perf_branches + 32'd1;
      if ((upd_pred_taken != upd_taken) && (perf_mispred != 32'hFFFF_FFFF)) begin
        perf_mispred <= perf_mispred + 32'd1;
      end
    end
  end

endmodule
